// File: rtl/div16.sv
// Iterative restoring divider: 32-bit dividend / 16-bit divisor, one quotient bit per clock.
// Out-of-range operations (zero divisor or quotient overflow) take a one-cycle error path.
module div16 (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] dividend,
   input  logic [15:0] divisor,
   output logic        busy,
   output logic        valid,
   output logic [15:0] quotient,
   output logic [15:0] remainder,
   output logic        div_by_zero,
   output logic        overflow
);

   typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

   state_t      state, state_next;
   logic [15:0] dvsr;
   logic [15:0] dvnd_lo;
   logic [16:0] part;
   logic [3:0]  count;
   logic [16:0] trial;
   logic [16:0] diff;
   logic        fits;
   logic        bad_op;
   logic        last_iter;

   // The partial remainder stays below the divisor, so one subtraction per step suffices.
   always_comb begin
      trial     = {part[15:0], dvnd_lo[15]};
      fits      = (trial >= {1'b0, dvsr});
      diff      = trial - {1'b0, dvsr};
      bad_op    = (divisor == 16'd0) || (dividend[31:16] >= divisor);
      last_iter = (count == 4'd15);
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = bad_op ? ERR : RUN;
         RUN:  if (last_iter) state_next = IDLE;
         ERR:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         dvsr        <= '0;
         dvnd_lo     <= '0;
         part        <= '0;
         count       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
         valid       <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  dvsr        <= divisor;
                  dvnd_lo     <= dividend[15:0];
                  part        <= {1'b0, dividend[31:16]};
                  count       <= '0;
                  quotient    <= '0;
                  remainder   <= '0;
                  div_by_zero <= 1'b0;
                  overflow    <= 1'b0;
               end
            end
            RUN: begin
               part     <= fits ? diff : trial;
               dvnd_lo  <= {dvnd_lo[14:0], 1'b0};
               quotient <= {quotient[14:0], fits};
               count    <= count + 4'd1;
               if (last_iter) begin
                  remainder <= fits ? diff[15:0] : trial[15:0];
                  valid     <= 1'b1;
               end
            end
            ERR: begin
               // Only reached when the divisor is zero or the quotient cannot fit in 16 bits.
               quotient    <= 16'hFFFF;
               remainder   <= dvnd_lo;
               div_by_zero <= (dvsr == 16'd0);
               overflow    <= (dvsr != 16'd0);
               valid       <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div16.sv
// Self-checking bench for div16: directed corner cases plus randomized operands
// compared against a plain-arithmetic reference model.
module tb_div16;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] dividend;
   logic [15:0] divisor;
   logic        busy;
   logic        valid;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;
   logic        overflow;

   int errors;
   int checks;

   div16 dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .valid      (valid),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model straight from the arithmetic definition.
   function automatic void model(input logic [31:0] a, input logic [15:0] b,
                                 output logic [15:0] q, output logic [15:0] r,
                                 output logic dz, output logic ov, output int lat);
      dz = 1'b0;
      ov = 1'b0;
      if (b == 16'd0) begin
         q = 16'hFFFF; r = a[15:0]; dz = 1'b1; lat = 1;
      end else if (a[31:16] >= b) begin
         q = 16'hFFFF; r = a[15:0]; ov = 1'b1; lat = 1;
      end else begin
         q = 16'(a / {16'd0, b});
         r = 16'(a % {16'd0, b});
         lat = 16;
      end
   endfunction

   // Drives one request and waits (bounded) for its valid pulse; lat=-1 on timeout.
   task automatic do_op(input logic [31:0] a, input logic [15:0] b,
                        output int lat, output logic clr_ok, output logic busy_ok);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      dividend = $urandom;
      divisor  = 16'($urandom);
      clr_ok   = (quotient == 16'd0) && (remainder == 16'd0) && !div_by_zero && !overflow && !valid;
      busy_ok  = busy;
      lat      = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      int vcount;
      reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, valid, quotient, remainder, div_by_zero, overflow} !== 35'd0) begin
         errors++;
         $display("[TB] FAIL reset_values: got busy=%b valid=%b q=%h r=%h dz=%b ov=%b, expected all zero",
                  busy, valid, quotient, remainder, div_by_zero, overflow);
      end
      dividend = 32'h00BC614E; divisor = 16'h1234; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; reset = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_beats_start: got busy=%b expected 0", busy);
      end
      vcount = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (valid) vcount++;
      end
      checks++;
      if (vcount != 0) begin
         errors++;
         $display("[TB] FAIL reset_beats_start_valid: got %0d valid pulses expected 0", vcount);
      end
   endtask

   task automatic test_basic;
      int lat; logic clr_ok, busy_ok;
      logic [15:0] q0, r0;
      do_op(32'h00BC614E, 16'h1234, lat, clr_ok, busy_ok);
      checks++;
      if (lat != 16 || !clr_ok || !busy_ok) begin
         errors++;
         $display("[TB] FAIL basic_timing: got lat=%0d clr=%b busy=%b expected lat=16 clr=1 busy=1", lat, clr_ok, busy_ok);
      end
      checks++;
      if ({quotient, remainder, div_by_zero, overflow} !== {16'h0A59, 16'h053A, 2'b00}) begin
         errors++;
         $display("[TB] FAIL basic_result: got q=%h r=%h dz=%b ov=%b expected q=0a59 r=053a dz=0 ov=0",
                  quotient, remainder, div_by_zero, overflow);
      end
      q0 = quotient; r0 = remainder;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_busy_at_valid: got %b expected 0", busy);
      end
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (valid !== 1'b0 || quotient !== 16'h0A59 || remainder !== 16'h053A) begin
         errors++;
         $display("[TB] FAIL basic_hold: got valid=%b q=%h r=%h expected valid=0 q=0a59 r=053a", valid, quotient, remainder);
      end
   endtask

   task automatic test_back_to_back;
      int lat; logic clr_ok, busy_ok;
      do_op(32'hFFFE0001, 16'hFFFF, lat, clr_ok, busy_ok);
      checks++;
      if (lat != 16 || quotient !== 16'hFFFF || remainder !== 16'h0000 || overflow !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_first: got lat=%0d q=%h r=%h ov=%b expected lat=16 q=ffff r=0000 ov=0",
                  lat, quotient, remainder, overflow);
      end
      do_op(32'h000F4240, 16'h03E8, lat, clr_ok, busy_ok);
      checks++;
      if (lat != 16 || !clr_ok || !busy_ok || quotient !== 16'h03E8 || remainder !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL b2b_second: got lat=%0d clr=%b busy=%b q=%h r=%h expected lat=16 clr=1 busy=1 q=03e8 r=0000",
                  lat, clr_ok, busy_ok, quotient, remainder);
      end
   endtask

   task automatic test_div_by_zero;
      int lat; logic clr_ok, busy_ok;
      repeat (2) @(posedge clk);
      #1;
      do_op(32'h12345678, 16'h0000, lat, clr_ok, busy_ok);
      checks++;
      if (lat != 1 || {quotient, remainder, div_by_zero, overflow} !== {16'hFFFF, 16'h5678, 2'b10}) begin
         errors++;
         $display("[TB] FAIL div_by_zero: got lat=%0d q=%h r=%h dz=%b ov=%b expected lat=1 q=ffff r=5678 dz=1 ov=0",
                  lat, quotient, remainder, div_by_zero, overflow);
      end
   endtask

   task automatic test_overflow;
      int lat; logic clr_ok, busy_ok;
      do_op(32'h00020000, 16'h0002, lat, clr_ok, busy_ok);
      checks++;
      if (lat != 1 || !clr_ok || {quotient, remainder, div_by_zero, overflow} !== {16'hFFFF, 16'h0000, 2'b01}) begin
         errors++;
         $display("[TB] FAIL overflow: got lat=%0d clr=%b q=%h r=%h dz=%b ov=%b expected lat=1 clr=1 q=ffff r=0000 dz=0 ov=1",
                  lat, clr_ok, quotient, remainder, div_by_zero, overflow);
      end
      // Boundary: high half equal to divisor is still an overflow.
      do_op(32'h1234FFFF, 16'h1234, lat, clr_ok, busy_ok);
      checks++;
      if (lat != 1 || {quotient, remainder, div_by_zero, overflow} !== {16'hFFFF, 16'hFFFF, 2'b01}) begin
         errors++;
         $display("[TB] FAIL overflow_equal: got lat=%0d q=%h r=%h dz=%b ov=%b expected lat=1 q=ffff r=ffff dz=0 ov=1",
                  lat, quotient, remainder, div_by_zero, overflow);
      end
   endtask

   task automatic test_ignore_start;
      int vcount, vlat;
      logic [15:0] vq, vr;
      repeat (2) @(posedge clk);
      #1;
      dividend = 32'h00BC614E; divisor = 16'h1234; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      vcount = 0; vlat = -1; vq = '0; vr = '0;
      for (int i = 1; i <= 30; i++) begin
         start = 1'b0;
         if (i == 3 || i == 10) begin
            start    = 1'b1;
            dividend = 32'h00000064;
            divisor  = 16'h0007;
         end
         @(posedge clk); #1;
         if (valid) begin
            vcount++;
            vlat = i;
            vq = quotient;
            vr = remainder;
         end
      end
      start = 1'b0;
      checks++;
      if (vcount != 1 || vlat != 16 || vq !== 16'h0A59 || vr !== 16'h053A) begin
         errors++;
         $display("[TB] FAIL ignore_start: got pulses=%0d lat=%0d q=%h r=%h expected pulses=1 lat=16 q=0a59 r=053a",
                  vcount, vlat, vq, vr);
      end
   endtask

   task automatic test_reset_abort;
      int vcount, lat;
      logic clr_ok, busy_ok;
      dividend = 32'h00BC614E; divisor = 16'h1234; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      vcount = 0;
      for (int i = 1; i <= 7; i++) begin
         @(posedge clk); #1;
         if (valid) vcount++;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if ({busy, valid, quotient, remainder, div_by_zero, overflow} !== 35'd0) begin
         errors++;
         $display("[TB] FAIL reset_abort_outputs: got busy=%b valid=%b q=%h r=%h dz=%b ov=%b expected all zero",
                  busy, valid, quotient, remainder, div_by_zero, overflow);
      end
      repeat (20) begin
         @(posedge clk); #1;
         if (valid) vcount++;
      end
      checks++;
      if (vcount != 0) begin
         errors++;
         $display("[TB] FAIL reset_abort_valid: got %0d valid pulses expected 0", vcount);
      end
      do_op(32'h000F4240, 16'h03E8, lat, clr_ok, busy_ok);
      checks++;
      if (lat != 16 || quotient !== 16'h03E8 || remainder !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL reset_abort_fresh: got lat=%0d q=%h r=%h expected lat=16 q=03e8 r=0000", lat, quotient, remainder);
      end
   endtask

   task automatic test_random(input int count);
      int lat, exp_lat;
      logic clr_ok, busy_ok;
      logic [31:0] a;
      logic [15:0] b, eq, er;
      logic edz, eov;
      logic [31:0] recon;
      for (int n = 0; n < count; n++) begin
         if (n % 8 == 7) begin
            a = $urandom;
            b = (n % 16 == 7) ? 16'd0 : 16'($urandom);
         end else begin
            b = 16'($urandom_range(1, 65535));
            a = {16'($urandom % {16'd0, b}), 16'($urandom)};
         end
         model(a, b, eq, er, edz, eov, exp_lat);
         do_op(a, b, lat, clr_ok, busy_ok);
         checks++;
         if (lat != exp_lat || !busy_ok ||
             {quotient, remainder, div_by_zero, overflow} !== {eq, er, edz, eov}) begin
            errors++;
            $display("[TB] FAIL random_%0d: a=%h b=%h got lat=%0d q=%h r=%h dz=%b ov=%b expected lat=%0d q=%h r=%h dz=%b ov=%b",
                     n, a, b, lat, quotient, remainder, div_by_zero, overflow, exp_lat, eq, er, edz, eov);
         end
         if (!edz && !eov) begin
            recon = 32'(quotient) * 32'(b) + 32'(remainder);
            checks++;
            if (recon !== a || remainder >= b) begin
               errors++;
               $display("[TB] FAIL random_invariant_%0d: q*d+r=%h r=%h expected dividend=%h with r < %h",
                        n, recon, remainder, a, b);
            end
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      test_reset;
      test_basic;
      test_back_to_back;
      test_div_by_zero;
      test_overflow;
      test_ignore_start;
      test_reset_abort;
      test_random(3000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
